// File: rtl/pirdsp_pkg.sv
// Shared helpers for the PIR-DSP SIMD blocks: ceil-log2, the accumulator
// width bound check and the packed lane/element slice offset helpers.
package pirdsp_pkg;

  // Extra bits a signed product of two (ELEM_W+1)-bit operands needs.
  localparam int PIRDSP_PROD_EXTRA = 32'sd2;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 32'sd0;
    v = 32'sd1;
    while (v < n) begin
      v = v * 32'sd2;
      r = r + 32'sd1;
    end
    return r;
  endfunction

  // The accumulator has to hold one exact lane sum without truncation.
  function automatic bit acc_w_ok(input int acc_w, input int elem_w, input int terms);
    return acc_w >= (32'sd2 * elem_w + PIRDSP_PROD_EXTRA + clog2(terms));
  endfunction

  // Bit offset of element (lane, term) in a packed operand bus.
  function automatic int elem_lo(input int lane, input int term, input int terms, input int elem_w);
    return (lane * terms + term) * elem_w;
  endfunction

  // Bit offset of a lane in a packed per-lane result bus.
  function automatic int lane_lo(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/pirdsp_dot_lane.sv
// One SIMD lane: extends TERMS element pairs to ELEM_W+1 bits (sign or zero),
// multiplies them as signed values and sums the products exactly into SUM_W bits.
// Purely combinational; the top registers the result.
module pirdsp_dot_lane
  import pirdsp_pkg::*;
#(
  parameter int TERMS  = 3,
  parameter int ELEM_W = 4,
  parameter int SUM_W  = 24
) (
  input  logic [TERMS*ELEM_W-1:0] a_i,
  input  logic [TERMS*ELEM_W-1:0] b_i,
  input  logic                    signed_i,
  output logic [SUM_W-1:0]        sum_o
);

  localparam int EXT_W  = ELEM_W + 1;
  localparam int PROD_W = 2 * ELEM_W + PIRDSP_PROD_EXTRA;

  logic signed [PROD_W-1:0] prod [TERMS];
  logic signed [SUM_W-1:0]  sum_acc;

  for (genvar t = 0; t < TERMS; t++) begin : g_term
    localparam int LO = elem_lo(0, t, TERMS, ELEM_W);
    logic signed [EXT_W-1:0] a_ext;
    logic signed [EXT_W-1:0] b_ext;
    // Top bit is the element MSB only in signed mode, so unsigned stays non-negative.
    assign a_ext   = {signed_i & a_i[LO+ELEM_W-1], a_i[LO +: ELEM_W]};
    assign b_ext   = {signed_i & b_i[LO+ELEM_W-1], b_i[LO +: ELEM_W]};
    assign prod[t] = PROD_W'(a_ext) * PROD_W'(b_ext);
  end

  // Sum the sign-extended products; SUM_W is wide enough that this is exact.
  always_comb begin
    sum_acc = {SUM_W{1'b0}};
    for (int t = 0; t < TERMS; t++) begin
      sum_acc = sum_acc + SUM_W'(prod[t]);
    end
  end

  assign sum_o = sum_acc;

endmodule

// File: rtl/pirdsp_simd_dotacc.sv
// SIMD dot-product-accumulate unit: LANES lanes of TERMS-element dot products,
// each added into a per-lane accumulator through a 2-stage valid/ready pipeline.
// S1 holds the lane sums and the beat's clear flag, S2 holds the accumulators.
// Optional build macro PIRDSP_DOTACC_SAT_EN: saturating accumulation with
// sticky per-lane out_sat flags; without it the add wraps and out_sat is 0.
module pirdsp_simd_dotacc
  import pirdsp_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int TERMS  = 3,
  parameter int ELEM_W = 4,
  parameter int ACC_W  = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*TERMS*ELEM_W-1:0] in_a,
  input  logic [LANES*TERMS*ELEM_W-1:0] in_b,
  input  logic                      in_signed,
  input  logic                      in_acc_clr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_y,
  output logic [LANES-1:0]          out_sat
);

  if (!acc_w_ok(ACC_W, ELEM_W, TERMS)) begin : g_acc_w_check
    $error("pirdsp_simd_dotacc: ACC_W too small for an exact lane sum");
  end

  localparam int LANE_IN_W = TERMS * ELEM_W;

  logic [ACC_W-1:0] lane_sum [LANES];
  logic [ACC_W-1:0] acc_nxt  [LANES];

  logic             rdy_en_q;
  logic             v1_q, v1_d;
  logic             clr1_q, clr1_d;
  logic [ACC_W-1:0] sum1_q [LANES];
  logic [ACC_W-1:0] sum1_d [LANES];
  logic             v2_q, v2_d;
  logic [ACC_W-1:0] acc_q  [LANES];
  logic [ACC_W-1:0] acc_d  [LANES];

  logic adv1, adv2, accept;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    pirdsp_dot_lane #(
      .TERMS (TERMS),
      .ELEM_W(ELEM_W),
      .SUM_W (ACC_W)
    ) u_lane (
      .a_i     (in_a[elem_lo(l, 0, TERMS, ELEM_W) +: LANE_IN_W]),
      .b_i     (in_b[elem_lo(l, 0, TERMS, ELEM_W) +: LANE_IN_W]),
      .signed_i(in_signed),
      .sum_o   (lane_sum[l])
    );
    assign out_y[lane_lo(l, ACC_W) +: ACC_W] = acc_q[l];
  end

  // Stage advance: S2 drains when its result is consumed, S1 when S2 can take it.
  // in_ready stays low during reset and for the first cycle after release.
  always_comb begin
    adv2   = v1_q & (~v2_q | out_ready);
    adv1   = ~v1_q | adv2;
    accept = in_valid & adv1 & rdy_en_q;
  end

  assign in_ready  = adv1 & rdy_en_q;
  assign out_valid = v2_q;

`ifdef PIRDSP_DOTACC_SAT_EN
  logic [ACC_W:0]   wide  [LANES];
  logic [LANES-1:0] clamp;
  logic [LANES-1:0] sat_q, sat_d;

  // Saturating accumulate: one extra bit detects overflow, then clamp to range.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      wide[l] = {acc_q[l][ACC_W-1], acc_q[l]} + {sum1_q[l][ACC_W-1], sum1_q[l]};
      if (clr1_q) begin
        clamp[l]   = 1'b0;
        acc_nxt[l] = sum1_q[l];
      end else if (wide[l][ACC_W] != wide[l][ACC_W-1]) begin
        clamp[l]   = 1'b1;
        acc_nxt[l] = wide[l][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        clamp[l]   = 1'b0;
        acc_nxt[l] = wide[l][ACC_W-1:0];
      end
    end
  end

  // Sticky clamp flags, cleared by a clear beat reaching S2.
  always_comb begin
    sat_d = sat_q;
    if (adv2) begin
      if (clr1_q) begin
        sat_d = {LANES{1'b0}};
      end else begin
        sat_d = sat_q | clamp;
      end
    end else begin
      sat_d = sat_q;
    end
  end

  // Saturation flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= {LANES{1'b0}};
    end else begin
      sat_q <= sat_d;
    end
  end

  assign out_sat = sat_q;
`else
  // Wrapping accumulate in ACC_W bits.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      if (clr1_q) begin
        acc_nxt[l] = sum1_q[l];
      end else begin
        acc_nxt[l] = acc_q[l] + sum1_q[l];
      end
    end
  end

  assign out_sat = {LANES{1'b0}};
`endif

  // Next state for both stages; registers only move on their advance condition.
  always_comb begin
    v1_d   = v1_q;
    clr1_d = clr1_q;
    v2_d   = v2_q;
    for (int l = 0; l < LANES; l++) begin
      sum1_d[l] = sum1_q[l];
      acc_d[l]  = acc_q[l];
    end
    if (adv1) begin
      v1_d = accept;
      if (accept) begin
        clr1_d = in_acc_clr;
        for (int l = 0; l < LANES; l++) begin
          sum1_d[l] = lane_sum[l];
        end
      end else begin
        clr1_d = clr1_q;
      end
    end else begin
      v1_d = v1_q;
    end
    if (adv2) begin
      v2_d = 1'b1;
      for (int l = 0; l < LANES; l++) begin
        acc_d[l] = acc_nxt[l];
      end
    end else if (out_ready) begin
      v2_d = 1'b0;
    end else begin
      v2_d = v2_q;
    end
  end

  // Pipeline registers; reset discards in-flight beats and zeroes accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q <= 1'b0;
      v1_q     <= 1'b0;
      clr1_q   <= 1'b0;
      v2_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        sum1_q[l] <= {ACC_W{1'b0}};
        acc_q[l]  <= {ACC_W{1'b0}};
      end
    end else begin
      rdy_en_q <= 1'b1;
      v1_q     <= v1_d;
      clr1_q   <= clr1_d;
      v2_q     <= v2_d;
      for (int l = 0; l < LANES; l++) begin
        sum1_q[l] <= sum1_d[l];
        acc_q[l]  <= acc_d[l];
      end
    end
  end

endmodule
